dram_req_bridge: RTL

Bridges the core's single-outstanding DRAM request port (dram_req_read/dram_req_write, 24-bit word address, 32-bit data) to the board SDRAM controller's valid/ready command interface. It sits directly downstream of the core, between the core's DMA-driven dram_* pins and the SDRAM controller. It converts level-held requests into exactly one controller command each, and returns one-cycle dram_data_valid / dram_write_complete pulses. An optional watchdog bounds every transaction.

---
 rtl/dram_req_bridge.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dram_req_bridge.sv
// dram_req_bridge: turns level-held core DRAM requests into single valid/ready controller commands.
// Optional watchdog is compiled in with `define DRAM_BRIDGE_TIMEOUT_EN.
module dram_req_bridge #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dram_req_read,
  input  logic              dram_req_write,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [DATA_W-1:0] dram_data_out,
  output logic [DATA_W-1:0] dram_data_in,
  output logic              dram_data_valid,
  output logic              dram_write_complete,
  output logic              ctl_cmd_valid,
  input  logic              ctl_cmd_ready,
  output logic              ctl_cmd_we,
  output logic [ADDR_W-1:0] ctl_cmd_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_rdata_valid,
  input  logic              ctl_wr_ack,
  output logic              bridge_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dram_req_bridge: TIMEOUT_CYCLES must be 2..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_RD,
    S_WAIT_WR,
    S_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rd_pls;
  logic              r_wr_pls;

  logic w_req_any;
  logic w_req_none;
  logic w_latch;
  logic w_rd_done;
  logic w_wr_done;
  logic w_tmo;
  logic w_tmo_hit;
  logic w_rd_pls;
  logic w_wr_pls;

  assign w_req_any  = dram_req_read | dram_req_write;
  assign w_req_none = ~w_req_any;

  // next-state and per-cycle event decode
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_CMD: begin
        if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (ctl_cmd_ready) begin
          w_state_nxt = r_we ? S_WAIT_WR : S_WAIT_RD;
        end
      end
      S_WAIT_RD: begin
        if (ctl_rdata_valid) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_WAIT_WR: begin
        if (ctl_wr_ack) begin
          w_wr_done   = 1'b1;
          w_state_nxt = S_RELEASE;
        end else if (w_tmo) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (w_req_none) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_rd_pls = w_rd_done | (w_tmo_hit & ~r_we);
  assign w_wr_pls = w_wr_done | (w_tmo_hit & r_we);

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // capture the request once in IDLE; write wins when both lines are high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_latch) begin
      r_we    <= dram_req_write;
      r_addr  <= dram_addr;
      r_wdata <= dram_data_out;
    end
  end

  // read data returned to the core, held between reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_rd_done) begin
      r_rdata <= ctl_rdata;
    end else if (w_tmo_hit && !r_we) begin
      r_rdata <= DATA_W'(32'hDEADBEEF);
    end
  end

  // one-cycle completion pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_pls <= 1'b0;
      r_wr_pls <= 1'b0;
    end else begin
      r_rd_pls <= w_rd_pls;
      r_wr_pls <= w_wr_pls;
    end
  end

`ifdef DRAM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_tmo_cnt;
  logic        r_err;
  logic        w_active;

  assign w_active = (r_state == S_CMD)
                  | (r_state == S_WAIT_RD)
                  | (r_state == S_WAIT_WR);

  // fires on the edge where the count reaches TIMEOUT_CYCLES
  assign w_tmo = w_active & (r_tmo_cnt >= TMO_LAST);

  // watchdog count: cleared on entry to CMD, saturates at the top
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_latch) begin
      r_tmo_cnt <= '0;
    end else if (w_active && r_tmo_cnt != 16'hFFFF) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  // sticky error; only a real timeout sets it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_tmo_hit) begin
      r_err <= 1'b1;
    end
  end

  assign bridge_err = r_err;
`else
  assign w_tmo      = 1'b0;
  assign bridge_err = 1'b0;
`endif

  assign ctl_cmd_valid       = (r_state == S_CMD);
  assign ctl_cmd_we          = r_we;
  assign ctl_cmd_addr        = r_addr;
  assign ctl_wdata           = r_wdata;
  assign dram_data_in        = r_rdata;
  assign dram_data_valid     = r_rd_pls;
  assign dram_write_complete = r_wr_pls;

endmodule
